// File: rtl/streamer_seq_pkg.sv
// streamer_seq_pkg: op codes, FSM states and done status codes for the streamer sequencer.
package streamer_seq_pkg;
  typedef enum logic [1:0] {OP_SAVE = 2'b00, OP_RESTORE = 2'b01, OP_CLEAR = 2'b10, OP_RSVD = 2'b11} op_e;
  typedef enum logic [2:0] {ST_IDLE, ST_CLR, ST_INIT, ST_WAIT, ST_DONE} state_e;
  typedef enum logic [1:0] {STS_OK = 2'b00, STS_ERR = 2'b01, STS_TIMEOUT = 2'b10} status_e;
endpackage

// File: rtl/streamer_slot_decode.sv
// streamer_slot_decode: slot index to one-hot slot vector, gated by an enable.
module streamer_slot_decode #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_IDX_WIDTH = 2
) (
  input  logic [SLOT_IDX_WIDTH-1:0] slot_i,
  input  logic                      en_i,
  output logic [NUM_SLOTS-1:0]      onehot_o
);
  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_dec
    assign onehot_o[s] = en_i && (32'(slot_i) == 32'(s));
  end
endmodule

// File: rtl/streamer_seq_ctrl.sv
// streamer_seq_ctrl: sequences reset/init strobes and completion for one streamer slot at a time.
// Optional WAIT watchdog is built when STREAMER_SEQ_TIMEOUT_EN is defined.
module streamer_seq_ctrl
  import streamer_seq_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_IDX_WIDTH = 2
`ifdef STREAMER_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TMO_WIDTH      = 16
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [SLOT_IDX_WIDTH-1:0] cmd_slot,
  output logic [NUM_SLOTS-1:0]      store_reset,
  output logic [NUM_SLOTS-1:0]      load_reset,
  output logic [NUM_SLOTS-1:0]      store_init,
  output logic [NUM_SLOTS-1:0]      load_init,
  input  logic [NUM_SLOTS-1:0]      fin_store,
  input  logic [NUM_SLOTS-1:0]      load_last,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                done_status
);
  state_e                    state_q, state_d;
  op_e                       op_q, op_d;
  status_e                   status_q, status_d;
  logic [SLOT_IDX_WIDTH-1:0] slot_q, slot_d;
  logic [NUM_SLOTS-1:0]      slot_oh;
  logic first_q, fin_sel, last_sel, evt, tmo_hit, legal;
  logic sr_en, lr_en, si_en, li_en;
  assign cmd_ready   = state_q == ST_IDLE;
  assign busy        = !cmd_ready;
  assign done_status = status_q;
  assign legal       = cmd_op != OP_RSVD && 32'(cmd_slot) < NUM_SLOTS;
  always_comb begin
    fin_sel  = 1'b0;
    last_sel = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      fin_sel  = fin_sel | (fin_store[i] & (32'(slot_q) == 32'(i)));
      last_sel = last_sel | (load_last[i] & (32'(slot_q) == 32'(i)));
    end
  end
  // A stale fin_store from an earlier save is still visible in the first WAIT cycle.
  assign evt = op_q == OP_SAVE ? fin_sel && !first_q : last_sel;
`ifdef STREAMER_SEQ_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_q;
  assign tmo_hit = tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else tmo_q <= state_q == ST_WAIT ? tmo_q + 1'b1 : '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    slot_d   = slot_q;
    status_d = status_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        op_d   = op_e'(cmd_op);
        slot_d = cmd_slot;
        if (legal) state_d = ST_CLR;
        else begin
          state_d  = ST_DONE;
          status_d = STS_ERR;
        end
      end
      ST_CLR: if (op_q == OP_CLEAR) begin
        state_d  = ST_DONE;
        status_d = STS_OK;
      end else state_d = ST_INIT;
      ST_INIT: state_d = ST_WAIT;
      ST_WAIT: if (evt) begin
        state_d  = ST_DONE;
        status_d = STS_OK;
      end else if (tmo_hit) begin
        state_d  = ST_DONE;
        status_d = STS_TIMEOUT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // Strobes are registered, so they are decoded from the state being entered.
  assign sr_en = state_d == ST_CLR && op_d != OP_RESTORE;
  assign lr_en = state_d == ST_CLR && op_d != OP_SAVE;
  assign si_en = state_d == ST_INIT && op_d == OP_SAVE;
  assign li_en = state_d == ST_INIT && op_d == OP_RESTORE;
  streamer_slot_decode #(.NUM_SLOTS(NUM_SLOTS), .SLOT_IDX_WIDTH(SLOT_IDX_WIDTH)) u_dec (
    .slot_i   (slot_d),
    .en_i     (state_d == ST_CLR || state_d == ST_INIT),
    .onehot_o (slot_oh)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SAVE;
      slot_q      <= '0;
      status_q    <= STS_OK;
      first_q     <= 1'b0;
      done        <= 1'b0;
      store_reset <= '0;
      load_reset  <= '0;
      store_init  <= '0;
      load_init   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      slot_q      <= slot_d;
      status_q    <= status_d;
      first_q     <= state_q == ST_INIT;
      done        <= state_d == ST_DONE;
      store_reset <= slot_oh & {NUM_SLOTS{sr_en}};
      load_reset  <= slot_oh & {NUM_SLOTS{lr_en}};
      store_init  <= slot_oh & {NUM_SLOTS{si_en}};
      load_init   <= slot_oh & {NUM_SLOTS{li_en}};
    end
  end
endmodule

// File: tb/tb_streamer_seq_ctrl.sv
// tb_streamer_seq_ctrl: directed scoreboard bench for streamer_seq_ctrl (3-bit slot index, 4 slots).
module tb_streamer_seq_ctrl;
  localparam int NS = 4;
  logic clk, reset, cmd_valid, cmd_ready, busy, done;
  logic [1:0] cmd_op, done_status;
  logic [2:0] cmd_slot;
  logic [NS-1:0] store_reset, load_reset, store_init, load_init, fin_store, load_last;
  int checks = 0, errors = 0, cyc = 0, t0 = 0;
  typedef struct {string tag; logic [1:0] st; int lat; int t0;} exp_t;
  exp_t sb[$];

  streamer_seq_ctrl #(
    .NUM_SLOTS(NS),
    .SLOT_IDX_WIDTH(3)
`ifdef STREAMER_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8),
    .TMO_WIDTH(16)
`endif
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_slot(cmd_slot), .store_reset(store_reset), .load_reset(load_reset),
    .store_init(store_init), .load_init(load_init), .fin_store(fin_store), .load_last(load_last),
    .busy(busy), .done(done), .done_status(done_status)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic strobes(input string tag, input logic [NS-1:0] sr, lr, si, li);
    chk(tag, {store_reset, load_reset, store_init, load_init}, {sr, lr, si, li});
  endtask

  task automatic at(input int k);
    for (int i = 0; i < 200 && cyc - t0 < k; i++) @(negedge clk);
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] slot,
                       input logic [1:0] st, input int lat);
    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    chk({tag, "_rdy"}, cmd_ready, 1);
    cmd_valid = 1;
    cmd_op    = op;
    cmd_slot  = slot;
    t0        = cyc;
    sb.push_back('{tag, st, lat, cyc});
    @(negedge clk);
    cmd_valid = 0;
    chk({tag, "_busy"}, {cmd_ready, busy}, 2'b01);
  endtask

  task automatic wait_done(input int budget);
    exp_t e;
    for (int n = 0; n < budget && !done; n++) @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_done"}, done, 1);
    chk({e.tag, "_lat"}, cyc - e.t0, e.lat);
    chk({e.tag, "_st"}, done_status, e.st);
  endtask

  initial begin
    reset = 1; cmd_valid = 0; cmd_op = 0; cmd_slot = 0; fin_store = 0; load_last = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", {cmd_ready, busy, done, done_status, store_reset, load_reset, store_init, load_init},
        {1'b1, 20'h0});
    reset = 0;
    @(negedge clk);

    issue("save2", 2'b00, 3'd2, 2'b00, 9);
    strobes("save2_c1", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    at(2);
    strobes("save2_c2", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    at(6);
    chk("save2_wait", {done, store_reset, load_reset, store_init, load_init}, 17'h0);
    at(8);
    fin_store = 4'b0100;
    wait_done(20);

    issue("save2_stale", 2'b00, 3'd2, 2'b00, 5);
    wait_done(20);
    fin_store = 0;

    issue("rest0", 2'b01, 3'd0, 2'b00, 11);
    strobes("rest0_c1", 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    at(2);
    strobes("rest0_c2", 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    at(5);
    load_last = 4'b0010;
    at(6);
    load_last = 0;
    at(10);
    load_last = 4'b0001;
    wait_done(20);
    load_last = 0;

    issue("clear3", 2'b10, 3'd3, 2'b00, 2);
    strobes("clear3_c1", 4'b1000, 4'b1000, 4'b0000, 4'b0000);
    wait_done(10);

    issue("ill_op", 2'b11, 3'd1, 2'b01, 1);
    strobes("ill_op_c1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_done(10);
    @(negedge clk);
    chk("ill_hold", {cmd_ready, done, done_status}, {1'b1, 1'b0, 2'b01});

    issue("ill_slot", 2'b00, 3'd5, 2'b01, 1);
    strobes("ill_slot_c1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_done(10);

`ifdef STREAMER_SEQ_TIMEOUT_EN
    issue("tmo", 2'b00, 3'd1, 2'b10, 11);
    wait_done(30);
    issue("tmo_ok", 2'b00, 3'd1, 2'b00, 11);
    at(10);
    fin_store = 4'b0010;
    wait_done(30);
    fin_store = 0;
`endif

    issue("rst_clr", 2'b01, 3'd1, 2'b00, 0);
    strobes("rst_clr_c1", 4'b0000, 4'b0010, 4'b0000, 4'b0000);
    reset = 1;
    #1;
    chk("rst_clr_async", {busy, done, store_reset, load_reset, store_init, load_init}, 18'h0);
    sb.delete();
    @(negedge clk);
    reset = 0;

    issue("rst_wait", 2'b01, 3'd2, 2'b00, 0);
    at(4);
    reset = 1;
    #1;
    chk("rst_wait_async", {cmd_ready, busy, done, done_status, store_reset, load_reset, store_init, load_init},
        {1'b1, 20'h0});
    sb.delete();
    @(negedge clk);
    reset = 0;
    chk("rst_release_rdy", cmd_ready, 1);

    issue("after_rst", 2'b00, 3'd3, 2'b00, 7);
    at(6);
    fin_store = 4'b1000;
    wait_done(20);
    fin_store = 0;

    for (int i = 0; i < 40 && !cmd_ready; i++) @(negedge clk);
    cmd_valid = 1; cmd_op = 2'b10; cmd_slot = 3'd0; t0 = cyc;
    at(1);
    chk("hold_c1", {cmd_ready, done, store_reset}, {1'b0, 1'b0, 4'b0001});
    at(2);
    chk("hold_c2", {cmd_ready, done}, 2'b01);
    at(3);
    chk("hold_c3", {cmd_ready, done, store_reset}, {1'b1, 1'b0, 4'b0000});
    at(4);
    chk("hold_c4", {cmd_ready, store_reset}, {1'b0, 4'b0001});
    cmd_valid = 0;
    at(5);
    chk("hold_c5", {cmd_ready, done}, 2'b01);
    at(6);
    chk("hold_c6", {cmd_ready, busy, store_reset}, {1'b1, 1'b0, 4'b0000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
